// File: rtl/lock_pkg.sv
// Purpose: shared types and default timing constants for the door lock actuator path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OPEN    = 2'b01,
        LOCKOUT = 2'b10
    } lock_state_t;

    localparam int DEF_OPEN_CYCLES    = 8;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;

    // Elaboration-time helper used to size the shared timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Purpose: loadable down-counter that stops at zero; is_zero flags expiry.
// Latency: load_value visible on the cycle after load; is_zero is a decode of the register.
// Backpressure: none; load always wins over the decrement.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset (count clears to 0)
//   load          reload the counter with load_value on this edge
//   load_value    value to load
//   is_zero       high while the count is zero
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         is_zero
);

    logic [W-1:0] cnt;

    // Counts down and parks at zero, so it needs no separate enable:
    // whoever loads it just watches is_zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/door_lock_ctrl.sv
// Purpose: door solenoid controller with failed-attempt counting and timed lockout/alarm.
// Latency: outputs registered, one edge after the unlock/attempt that causes them.
// Backpressure: none; inputs are sampled every edge, ignored in states that don't use them.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   unlock       pattern-detector match (high = correct code)
//   attempt      one-cycle strobe marking the end of an entry attempt
//   door_open    solenoid release
//   locked_out   lockout active
//   alarm        siren; mirrors locked_out
//   fail_cnt     consecutive failed attempts, saturating at MAX_FAILS
module door_lock_ctrl
    import lock_pkg::*;
#(
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               unlock,
    input  logic                               attempt,
    output logic                               door_open,
    output logic                               locked_out,
    output logic                               alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);

    localparam logic [TW-1:0] OPEN_LOAD    = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAILS);
    localparam logic [FW:0]   FAIL_LIMIT   = (FW+1)'(MAX_FAILS);

    lock_state_t   state, state_nxt;
    logic [FW-1:0] fail_nxt;
    logic [FW:0]   fail_inc;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_zero;
    logic          door_open_nxt;
    logic          locked_out_nxt;

    cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .is_zero    (tmr_zero)
    );

    // One extra bit so the "would reach the limit" test cannot overflow.
    assign fail_inc = {1'b0, fail_cnt} + (FW+1)'(1);

    // State register plus registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fail_cnt   <= '0;
            door_open  <= 1'b0;
            locked_out <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_nxt;
            fail_cnt   <= fail_nxt;
            door_open  <= door_open_nxt;
            locked_out <= locked_out_nxt;
            alarm      <= locked_out_nxt;
        end
    end

    // Next-state, fail counter and timer control.
    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        tmr_load  = 1'b0;
        tmr_value = OPEN_LOAD;

        case (state)
            IDLE: begin
                if (unlock) begin
                    // A correct code beats a simultaneous attempt strobe.
                    state_nxt = OPEN;
                    tmr_load  = 1'b1;
                    tmr_value = OPEN_LOAD;
                    fail_nxt  = '0;
                end else if (attempt) begin
                    if (fail_inc < FAIL_LIMIT) begin
                        fail_nxt = fail_inc[FW-1:0];
                    end else begin
                        state_nxt = LOCKOUT;
                        tmr_load  = 1'b1;
                        tmr_value = LOCKOUT_LOAD;
                        fail_nxt  = FAIL_MAX;
                    end
                end
            end

            OPEN: begin
                // Reloading on the last cycle keeps door_open high with no gap.
                if (unlock) begin
                    tmr_load  = 1'b1;
                    tmr_value = OPEN_LOAD;
                end else if (tmr_zero) begin
                    state_nxt = IDLE;
                end
            end

            LOCKOUT: begin
                // unlock on the expiry edge is deliberately dropped.
                if (tmr_zero) begin
                    state_nxt = IDLE;
                    fail_nxt  = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
                fail_nxt  = '0;
            end
        endcase
    end

    // Outputs decoded from the next state, then registered above.
    always_comb begin
        door_open_nxt  = (state_nxt == OPEN);
        locked_out_nxt = (state_nxt == LOCKOUT);
    end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Purpose: directed bench for door_lock_ctrl with a queue-based scoreboard.
// Latency: expected values are those seen one edge after each driven vector.
// Backpressure: n/a.
module tb_door_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       unlock = 1'b0;
    logic       attempt = 1'b0;
    logic       door_open;
    logic       locked_out;
    logic       alarm;
    logic [1:0] fail_cnt;

    typedef struct packed {
        logic       door;
        logic       lock;
        logic [1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    door_lock_ctrl #(
        .OPEN_CYCLES    (8),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .unlock     (unlock),
        .attempt    (attempt),
        .door_open  (door_open),
        .locked_out (locked_out),
        .alarm      (alarm),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".door_open"},  int'(door_open),  int'(e.door));
        chk({tag, ".locked_out"}, int'(locked_out), int'(e.lock));
        chk({tag, ".alarm"},      int'(alarm),      int'(e.lock));
        chk({tag, ".fail_cnt"},   int'(fail_cnt),   int'(e.fc));
    endtask

    // Drive one vector before the next rising edge and queue what the
    // outputs must show after that edge.
    task automatic step(input logic u, input logic a, input logic ed,
                        input logic el, input logic [1:0] ef);
        exp_t e;
        @(negedge clk);
        unlock  = u;
        attempt = a;
        e.door = ed;
        e.lock = el;
        e.fc   = ef;
        exp_q.push_back(e);
    endtask

    task automatic async_reset_check(input string tag);
        exp_t z;
        z = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all(tag, z);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: outputs are sampled just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all("mon", e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t z;
        z = '0;
        #2;
        chk_all("reset", z);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);

        // Single unlock: exactly 8 cycles open.
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Three failures -> 16 cycles of lockout, then counter clears.
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 2);
        step(0, 1, 0, 1, 3);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Two failures, then unlock with attempt: unlock wins.
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 2);
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, (i % 2 == 0), 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Two more failures lock out; inputs hammered during lockout.
        step(0, 1, 0, 0, 2);
        step(0, 1, 0, 1, 3);
        for (int i = 0; i < 15; i++) step((i % 2 == 0), (i % 2 == 1), 0, 1, 3);
        step(1, 0, 0, 0, 0);   // unlock on the expiry edge: ignored
        step(1, 0, 1, 0, 0);   // first IDLE cycle: honoured
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Re-unlock on the final OPEN cycle: no gap on door_open.
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Async reset mid-OPEN.
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        async_reset_check("rst_open");
        step(0, 0, 0, 0, 0);

        // Async reset mid-LOCKOUT.
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 2);
        step(0, 1, 0, 1, 3);
        step(0, 0, 0, 1, 3);
        step(0, 0, 0, 1, 3);
        async_reset_check("rst_lockout");
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        @(negedge clk);
        unlock  = 1'b0;
        attempt = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
